// File: rtl/ili9341_spi_slave.sv
// ili9341_spi_slave
//   SPI mode-0 responder for the ILI9341 4-wire link. The SPI pins are
//   asynchronous to clk. They are oversampled through SYNC_STAGES flops.
//   Received bytes are tagged with the DC level. Read-back bytes are shifted
//   out on miso, MSB first.
// Ports
//   clk, rst (async, active-low)
//   sclk, mosi, cs (active-low), dc      SPI pins from the master
//   tx_byte / tx_ack                     byte to return; ack = captured
//   miso                                 serial data out (MISO_IDLE when idle)
//   rx_byte, rx_dc, rx_first, rx_valid   received byte and its tags
//   frame_err                            cs rose while a byte was incomplete
//   byte_cnt                             bytes this transaction, saturating
//   busy                                 transaction in progress
module ili9341_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic        MISO_IDLE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             cs,
  input  logic             dc,
  input  logic [7:0]       tx_byte,
  output logic             miso,
  output logic             tx_ack,
  output logic [7:0]       rx_byte,
  output logic             rx_dc,
  output logic             rx_first,
  output logic             rx_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             busy
);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, dc_sync, cs_sync;
  logic sclk_s, mosi_s, dc_s, cs_s;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic       start, stop, do_rise, do_fall;
  logic [7:0] rx_sr;
  // Only the bits still to be sent are kept. Bit 7 goes straight to miso at load.
  logic [6:0] tx_sr;
  logic [2:0] bit_cnt;
  logic       first_flag, reload, byte_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A cs edge masks any sclk edge in the same cycle.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    do_rise = 1'b0;
    do_fall = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          do_rise = sclk_rise;
          do_fall = sclk_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso       <= MISO_IDLE;
      tx_ack     <= 1'b0;
      rx_byte    <= '0;
      rx_dc      <= 1'b0;
      rx_first   <= 1'b0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      byte_cnt   <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      first_flag <= 1'b0;
      reload     <= 1'b0;
      byte_done  <= 1'b0;
    end else begin
      tx_ack    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      byte_done <= 1'b0;

      if (do_rise) begin
        rx_sr     <= {rx_sr[6:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end

      if (do_fall) begin
        if (reload) begin
          tx_sr  <= tx_byte[6:0];
          miso   <= tx_byte[7];
          tx_ack <= 1'b1;
          reload <= 1'b0;
        end else begin
          tx_sr <= {tx_sr[5:0], 1'b0};
          miso  <= tx_sr[6];
        end
      end

      // A completed byte is published even if cs rises in this same cycle.
      // The stop branch below then cancels the reload.
      if (byte_done) begin
        rx_byte    <= rx_sr;
        rx_dc      <= dc_s;
        rx_first   <= first_flag;
        rx_valid   <= 1'b1;
        first_flag <= 1'b0;
        reload     <= 1'b1;
        if (byte_cnt != '1) byte_cnt <= byte_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (stop) begin
        frame_err <= (bit_cnt != 3'd0);
        miso      <= MISO_IDLE;
        reload    <= 1'b0;
        bit_cnt   <= '0;
      end

      if (start) begin
        bit_cnt    <= '0;
        byte_cnt   <= '0;
        first_flag <= 1'b1;
        tx_sr      <= tx_byte[6:0];
        miso       <= tx_byte[7];
        tx_ack     <= 1'b1;
        reload     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ili9341_spi_slave.sv
// tb_ili9341_spi_slave
//   Self-checking bench for ili9341_spi_slave. It drives the SPI pins as a
//   mode-0 master. A monitor logs every rx_valid record and counts the
//   tx_ack and frame_err pulses. Each test builds its expected byte stream
//   from the protocol rules and compares it against that log.
module tb_ili9341_spi_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs = 1'b1;
  logic        dc = 1'b0;
  logic [7:0]  tx_byte = 8'h00;
  logic        miso, tx_ack, rx_dc, rx_first, rx_valid, frame_err, busy;
  logic [7:0]  rx_byte;
  logic [15:0] byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ili9341_spi_slave #(.SYNC_STAGES(2), .CNT_W(16), .MISO_IDLE(1'b1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .dc(dc),
    .tx_byte(tx_byte), .miso(miso), .tx_ack(tx_ack), .rx_byte(rx_byte),
    .rx_dc(rx_dc), .rx_first(rx_first), .rx_valid(rx_valid),
    .frame_err(frame_err), .byte_cnt(byte_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: one log entry per rx_valid cycle, plus pulse-cycle counters.
  logic [7:0] log_byte[$];
  logic       log_dc[$];
  logic       log_first[$];
  int rx_cnt = 0, ack_cnt = 0, ferr_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      log_byte.push_back(rx_byte);
      log_dc.push_back(rx_dc);
      log_first.push_back(rx_first);
      rx_cnt++;
    end
    if (tx_ack)    ack_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: data is set up while sclk is low, and miso is sampled
  // just before the rising edge, as a master would sample it.
  task automatic spi_bit(input logic b, input logic d, input int hp, output logic mi);
    mosi = b;
    dc   = d;
    wait_clks(hp);
    mi   = miso;
    sclk = 1'b1;
    wait_clks(hp);
    sclk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input logic d, input int hp, output logic [7:0] mi);
    logic bv;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(mo[i], d, hp, bv);
      mi[i] = bv;
    end
  endtask

  task automatic cs_down;
    cs = 1'b0;
    wait_clks(2);
  endtask

  task automatic cs_up;
    wait_clks(4);
    cs = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    wait_clks(3);
    n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso got=%b exp=1", miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if ({rx_valid, tx_ack, frame_err, rx_dc, rx_first} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=00000", {rx_valid, tx_ack, frame_err, rx_dc, rx_first}); end
    n_checks++; if ({rx_byte, byte_cnt} !== 24'h0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=000000", {rx_byte, byte_cnt}); end
    rst = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_cmd_data;
    logic [7:0] seq[5] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'hEF};
    logic [7:0] mi;
    int base = rx_cnt;
    int fbase = ferr_cnt;
    cs_down();
    wait_clks(4);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cmd_busy got=%b exp=1", busy); end
    for (int i = 0; i < 5; i++) spi_xfer(seq[i], (i != 0), 4, mi);
    cs_up();
    n_checks++; if (rx_cnt - base !== 5) begin n_fail++; $display("FAIL cmd_count got=%0d exp=5", rx_cnt - base); end
    for (int i = 0; i < 5 && base + i < rx_cnt; i++) begin
      n_checks++;
      if ({log_byte[base+i], log_dc[base+i], log_first[base+i]} !== {seq[i], (i != 0), (i == 0)}) begin
        n_fail++;
        $display("FAIL cmd_rec%0d got=%h/%b/%b exp=%h/%b/%b", i, log_byte[base+i], log_dc[base+i],
                 log_first[base+i], seq[i], (i != 0), (i == 0));
      end
    end
    n_checks++; if (byte_cnt !== 16'd5) begin n_fail++; $display("FAIL cmd_byte_cnt got=%0d exp=5", byte_cnt); end
    n_checks++; if (ferr_cnt != fbase) begin n_fail++; $display("FAIL cmd_frame_err got=%0d exp=0", ferr_cnt - fbase); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cmd_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_readback;
    logic [15:0] mo = 16'($urandom);
    logic [15:0] mi;
    logic bv;
    int abase = ack_cnt;
    int base = rx_cnt;
    int fbase = ferr_cnt;
    int t = 0;
    tx_byte = 8'hA5;
    wait_clks(2);
    cs = 1'b0;
    while (ack_cnt == abase && t < 20) begin
      @(posedge clk); #1; t++;
    end
    n_checks++; if (ack_cnt == abase) begin n_fail++; $display("FAIL rb_first_ack got=none exp=pulse"); end
    tx_byte = 8'h3C;
    for (int i = 15; i >= 1; i--) begin
      spi_bit(mo[i], 1'b1, 8, bv);
      mi[i] = bv;
    end
    // The final falling edge coincides with cs rising, so it must not reload.
    mosi = mo[0];
    wait_clks(8);
    mi[0] = miso;
    sclk = 1'b1;
    wait_clks(8);
    sclk = 1'b0;
    cs   = 1'b1;
    wait_clks(10);
    n_checks++; if (mi !== 16'hA53C) begin n_fail++; $display("FAIL rb_miso got=%h exp=a53c", mi); end
    n_checks++; if (ack_cnt - abase !== 2) begin n_fail++; $display("FAIL rb_ack_count got=%0d exp=2", ack_cnt - abase); end
    n_checks++; if (rx_cnt - base !== 2) begin n_fail++; $display("FAIL rb_rx_count got=%0d exp=2", rx_cnt - base); end
    else begin
      n_checks++; if ({log_byte[base], log_byte[base+1]} !== mo) begin
        n_fail++; $display("FAIL rb_rx_bytes got=%h%h exp=%h", log_byte[base], log_byte[base+1], mo); end
    end
    n_checks++; if (ferr_cnt != fbase) begin n_fail++; $display("FAIL rb_frame_err got=%0d exp=0", ferr_cnt - fbase); end
    n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL rb_miso_idle got=%b exp=1", miso); end
  endtask

  task automatic test_abort;
    logic bv;
    logic [7:0] mi;
    int base = rx_cnt;
    int fbase = ferr_cnt;
    cs_down();
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom), 1'b1, 4, bv);
    cs_up();
    n_checks++; if (ferr_cnt - fbase !== 1) begin n_fail++; $display("FAIL abort_frame_err got=%0d exp=1", ferr_cnt - fbase); end
    n_checks++; if (rx_cnt != base) begin n_fail++; $display("FAIL abort_rx got=%0d exp=0", rx_cnt - base); end
    n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL abort_miso got=%b exp=1", miso); end
    cs_down();
    spi_xfer(8'h55, 1'b1, 4, mi);
    cs_up();
    n_checks++; if (rx_cnt - base !== 1) begin n_fail++; $display("FAIL abort_next_count got=%0d exp=1", rx_cnt - base); end
    else begin
      n_checks++; if ({log_byte[base], log_first[base]} !== {8'h55, 1'b1}) begin
        n_fail++; $display("FAIL abort_next_rec got=%h/%b exp=55/1", log_byte[base], log_first[base]); end
    end
    n_checks++; if (ferr_cnt - fbase !== 1) begin n_fail++; $display("FAIL abort_next_ferr got=%0d exp=1", ferr_cnt - fbase); end
  endtask

  task automatic test_async_reset;
    logic bv;
    logic [7:0] mi;
    int base;
    cs_down();
    wait_clks(3);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b1, 4, bv);
    mosi = 1'b1;
    wait_clks(4);
    sclk = 1'b1;
    wait_clks(3);
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({busy, miso, rx_valid, frame_err, tx_ack} !== 5'b01000) begin
      n_fail++; $display("FAIL arst_outputs got=%b exp=01000", {busy, miso, rx_valid, frame_err, tx_ack}); end
    n_checks++; if ({rx_byte, byte_cnt} !== 24'h0) begin
      n_fail++; $display("FAIL arst_data got=%h exp=000000", {rx_byte, byte_cnt}); end
    sclk = 1'b0;
    cs   = 1'b1;
    wait_clks(4);
    rst = 1'b1;
    wait_clks(6);
    base = rx_cnt;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_idle got=%b exp=0", busy); end
    cs_down();
    spi_xfer(8'h81, 1'b1, 4, mi);
    cs_up();
    n_checks++; if (rx_cnt - base !== 1 || rx_byte !== 8'h81) begin
      n_fail++; $display("FAIL arst_next got=%0d/%h exp=1/81", rx_cnt - base, rx_byte); end
  endtask

  task automatic test_idle_noise;
    int base = rx_cnt;
    int abase = ack_cnt;
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      dc   = 1'($urandom);
      sclk = ~sclk;
      for (int k = 0; k < 4; k++) begin
        wait_clks(1);
        if (miso !== 1'b1 || busy !== 1'b0) bad++;
      end
    end
    sclk = 1'b0;
    wait_clks(6);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL noise_idle got=%0d bad_cycles exp=0", bad); end
    n_checks++; if (rx_cnt != base || ack_cnt != abase) begin
      n_fail++; $display("FAIL noise_pulses got=%0d/%0d exp=0/0", rx_cnt - base, ack_cnt - abase); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[$];
    logic       exp_d[$];
    logic [7:0] mi;
    int base = rx_cnt;
    int fbase = ferr_cnt;
    int bad = 0;
    cs_down();
    for (int i = 0; i < 300; i++) begin
      exp_b.push_back(8'($urandom));
      exp_d.push_back(1'($urandom));
      spi_xfer(exp_b[i], exp_d[i], 4, mi);
    end
    cs_up();
    n_checks++; if (rx_cnt - base !== 300) begin n_fail++; $display("FAIL b2b_count got=%0d exp=300", rx_cnt - base); end
    for (int i = 0; i < 300 && base + i < rx_cnt; i++)
      if ({log_byte[base+i], log_dc[base+i], log_first[base+i]} !== {exp_b[i], exp_d[i], (i == 0)}) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_records got=%0d wrong exp=0", bad); end
    n_checks++; if (byte_cnt !== 16'd300) begin n_fail++; $display("FAIL b2b_byte_cnt got=%0d exp=300", byte_cnt); end
    n_checks++; if (ferr_cnt != fbase) begin n_fail++; $display("FAIL b2b_frame_err got=%0d exp=0", ferr_cnt - fbase); end
  endtask

  initial begin
    test_reset();
    test_cmd_data();
    test_readback();
    test_abort();
    test_async_reset();
    test_idle_noise();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
